// File: rtl/srl_bank.sv
// srl_bank: a bank of independent set/reset flags fed by asynchronous request
// lines. Each request is synchronized, optionally edge-qualified, and resolved
// against the current flag state. Registered rise/fall pulses and an any-set
// summary are produced alongside the flags.
module srl_bank #(
  parameter int                  CHANNELS    = 4,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  PRIORITY    = 0,
  parameter int                  EDGE_MODE   = 0,
  parameter logic [CHANNELS-1:0] INIT        = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] s,
  input  logic [CHANNELS-1:0] r,
  input  logic [CHANNELS-1:0] clr,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] q_rise,
  output logic [CHANNELS-1:0] q_fall,
  output logic                any_set
);

  logic [CHANNELS-1:0] s_pipe [SYNC_STAGES];
  logic [CHANNELS-1:0] r_pipe [SYNC_STAGES];
  logic [CHANNELS-1:0] s_sync;
  logic [CHANNELS-1:0] r_sync;
  logic [CHANNELS-1:0] set_ev;
  logic [CHANNELS-1:0] rst_ev;
  logic [CHANNELS-1:0] q_next;

  // Resolve one channel's next flag value; clr always wins, then the
  // simultaneous set/reset policy, then single requests, else hold.
  function automatic logic resolve(input logic q_cur, input logic se,
                                   input logic re, input logic ce);
    logic res;
    res = q_cur;
    if (ce) begin
      res = 1'b0;
    end else if (se && re) begin
      if (PRIORITY == 1)      res = 1'b1;
      else if (PRIORITY == 2) res = ~q_cur;
      else                    res = 1'b0;
    end else if (se) begin
      res = 1'b1;
    end else if (re) begin
      res = 1'b0;
    end
    return res;
  endfunction

  // Stage boundary: synchronizer chains, plain flop-to-flop with no logic between.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        s_pipe[k] <= '0;
        r_pipe[k] <= '0;
      end
    end else begin
      s_pipe[0] <= s;
      r_pipe[0] <= r;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        s_pipe[k] <= s_pipe[k-1];
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  assign s_sync = s_pipe[SYNC_STAGES-1];
  assign r_sync = r_pipe[SYNC_STAGES-1];

  generate
    if (EDGE_MODE != 0) begin : g_edge
      logic [CHANNELS-1:0] s_prev;
      logic [CHANNELS-1:0] r_prev;

      // Stage boundary: one-cycle history of the synced requests for rising-edge detection.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s_prev <= '0;
          r_prev <= '0;
        end else begin
          s_prev <= s_sync;
          r_prev <= r_sync;
        end
      end

      assign set_ev = s_sync & ~s_prev;
      assign rst_ev = r_sync & ~r_prev;
    end else begin : g_level
      assign set_ev = s_sync;
      assign rst_ev = r_sync;
    end
  endgenerate

  // Per-channel next-state resolution from events, clear and current state.
  always_comb begin
    q_next = q;
    for (int i = 0; i < CHANNELS; i++) begin
      q_next[i] = resolve(q[i], set_ev[i], rst_ev[i], clr[i]);
    end
  end

  // Stage boundary: flag state, transition pulses and summary all update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q       <= INIT;
      q_rise  <= '0;
      q_fall  <= '0;
      any_set <= |INIT;
    end else begin
      q       <= q_next;
      q_rise  <= q_next & ~q;
      q_fall  <= ~q_next & q;
      any_set <= |q_next;
    end
  end

endmodule

// File: tb/tb_srl_bank.sv
// Testbench for srl_bank: four instances sharing stimulus, covering
// reset-dominant, set-dominant, toggle and edge-qualified configurations.
module tb_srl_bank;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] s, r, clr;
  logic [3:0] qv [4];
  logic [3:0] qr [4];
  logic [3:0] qf [4];
  logic       anyv [4];
  int         n_cmp = 0;
  int         n_bad = 0;

  // dut 0: level, reset-dominant
  srl_bank #(.CHANNELS(4), .SYNC_STAGES(2), .PRIORITY(0), .EDGE_MODE(0), .INIT(4'b0101)) u_p0 (
    .clk(clk), .rst(rst), .s(s), .r(r), .clr(clr),
    .q(qv[0]), .q_rise(qr[0]), .q_fall(qf[0]), .any_set(anyv[0]));
  // dut 1: level, set-dominant
  srl_bank #(.CHANNELS(4), .SYNC_STAGES(2), .PRIORITY(1), .EDGE_MODE(0), .INIT(4'b0101)) u_p1 (
    .clk(clk), .rst(rst), .s(s), .r(r), .clr(clr),
    .q(qv[1]), .q_rise(qr[1]), .q_fall(qf[1]), .any_set(anyv[1]));
  // dut 2: level, toggle
  srl_bank #(.CHANNELS(4), .SYNC_STAGES(2), .PRIORITY(2), .EDGE_MODE(0), .INIT(4'b0101)) u_p2 (
    .clk(clk), .rst(rst), .s(s), .r(r), .clr(clr),
    .q(qv[2]), .q_rise(qr[2]), .q_fall(qf[2]), .any_set(anyv[2]));
  // dut 3: edge-qualified, reset-dominant
  srl_bank #(.CHANNELS(4), .SYNC_STAGES(2), .PRIORITY(0), .EDGE_MODE(1), .INIT(4'b0101)) u_e0 (
    .clk(clk), .rst(rst), .s(s), .r(r), .clr(clr),
    .q(qv[3]), .q_rise(qr[3]), .q_fall(qf[3]), .any_set(anyv[3]));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; s = '0; r = '0; clr = '0;
    tick(); tick();
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (qv[d] !== 4'b0101) begin n_bad++; $display("FAIL reset_q dut%0d got %b want 0101", d, qv[d]); end
      n_cmp++; if (qr[d] !== 4'b0000) begin n_bad++; $display("FAIL reset_rise dut%0d got %b want 0000", d, qr[d]); end
      n_cmp++; if (qf[d] !== 4'b0000) begin n_bad++; $display("FAIL reset_fall dut%0d got %b want 0000", d, qf[d]); end
      n_cmp++; if (anyv[d] !== 1'b1) begin n_bad++; $display("FAIL reset_any dut%0d got %b want 1", d, anyv[d]); end
    end
    rst = 1'b1;
    repeat (4) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        n_cmp++; if (qv[d] !== 4'b0101 || anyv[d] !== 1'b1) begin
          n_bad++; $display("FAIL reset_hold dut%0d got q=%b any=%b want q=0101 any=1", d, qv[d], anyv[d]);
        end
      end
    end
  endtask

  task automatic test_latency();
    int nr [4];
    int nf [4];
    clr = 4'b0100; tick(); clr = '0;
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (qv[d][2] !== 1'b0 || qf[d][2] !== 1'b1) begin
        n_bad++; $display("FAIL clr_latency dut%0d got q2=%b fall2=%b want 0 1", d, qv[d][2], qf[d][2]);
      end
    end
    tick();
    s[2] = 1'b1;
    tick(); tick();
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (qv[d][2] !== 1'b0) begin n_bad++; $display("FAIL set_early dut%0d got q2=%b want 0", d, qv[d][2]); end
    end
    tick();
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (qv[d][2] !== 1'b1 || qr[d][2] !== 1'b1) begin
        n_bad++; $display("FAIL set_latency dut%0d got q2=%b rise2=%b want 1 1", d, qv[d][2], qr[d][2]);
      end
    end
    tick();
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (qv[d][2] !== 1'b1 || qr[d][2] !== 1'b0) begin
        n_bad++; $display("FAIL rise_oneshot dut%0d got q2=%b rise2=%b want 1 0", d, qv[d][2], qr[d][2]);
      end
    end
    s[2] = 1'b0; r[2] = 1'b1;
    for (int d = 0; d < 4; d++) begin nr[d] = 0; nf[d] = 0; end
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 3) r[2] = 1'b0;
      for (int d = 0; d < 4; d++) begin
        if (qr[d][2] === 1'b1) nr[d]++;
        if (qf[d][2] === 1'b1) nf[d]++;
      end
    end
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (qv[d][2] !== 1'b0 || nf[d] != 1 || nr[d] != 0) begin
        n_bad++; $display("FAIL reset_pulse dut%0d got q2=%b falls=%0d rises=%0d want 0 1 0", d, qv[d][2], nf[d], nr[d]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic e2q [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic e2r [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic e2f [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic e1q [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    s[1] = 1'b1; r[1] = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t == 4) begin s[1] = 1'b0; r[1] = 1'b0; end
      n_cmp++; if (qv[2][1] !== e2q[t-1] || qr[2][1] !== e2r[t-1] || qf[2][1] !== e2f[t-1]) begin
        n_bad++; $display("FAIL toggle t%0d got q1=%b rise1=%b fall1=%b want %b %b %b",
                          t, qv[2][1], qr[2][1], qf[2][1], e2q[t-1], e2r[t-1], e2f[t-1]);
      end
      n_cmp++; if (qv[1][1] !== e1q[t-1]) begin n_bad++; $display("FAIL set_dom t%0d got q1=%b want %b", t, qv[1][1], e1q[t-1]); end
      n_cmp++; if (qv[0][1] !== 1'b0) begin n_bad++; $display("FAIL rst_dom t%0d got q1=%b want 0", t, qv[0][1]); end
    end
    n_cmp++; if (qv[3][1] !== 1'b0) begin n_bad++; $display("FAIL edge_both got q1=%b want 0", qv[3][1]); end
  endtask

  task automatic test_edge_clr();
    int r0, f0, r3, f3;
    clr = 4'b0001; tick(); clr = '0; tick();
    n_cmp++; if (anyv[0] !== 1'b0) begin n_bad++; $display("FAIL any_clear dut0 got %b want 0", anyv[0]); end
    n_cmp++; if (anyv[1] !== 1'b1) begin n_bad++; $display("FAIL any_keep dut1 got %b want 1", anyv[1]); end
    r0 = 0; f0 = 0; r3 = 0; f3 = 0;
    s[0] = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 6) clr[0] = 1'b1;
      if (t == 7) clr[0] = 1'b0;
      if (t == 10) s[0] = 1'b0;
      if (qr[0][0] === 1'b1) r0++;
      if (qf[0][0] === 1'b1) f0++;
      if (qr[3][0] === 1'b1) r3++;
      if (qf[3][0] === 1'b1) f3++;
      if (t == 3) begin
        n_cmp++; if (qv[3][0] !== 1'b1) begin n_bad++; $display("FAIL edge_set got q0=%b want 1", qv[3][0]); end
      end
      if (t == 7) begin
        n_cmp++; if (qv[3][0] !== 1'b0 || qv[0][0] !== 1'b0) begin
          n_bad++; $display("FAIL edge_clr got e=%b l=%b want 0 0", qv[3][0], qv[0][0]);
        end
      end
      if (t == 8) begin
        n_cmp++; if (qv[3][0] !== 1'b0 || qv[0][0] !== 1'b1) begin
          n_bad++; $display("FAIL after_clr got e=%b l=%b want 0 1", qv[3][0], qv[0][0]);
        end
      end
    end
    n_cmp++; if (qv[3][0] !== 1'b0 || r3 != 1 || f3 != 1) begin
      n_bad++; $display("FAIL edge_once got q0=%b rises=%0d falls=%0d want 0 1 1", qv[3][0], r3, f3);
    end
    n_cmp++; if (qv[0][0] !== 1'b1 || r0 != 2 || f0 != 1) begin
      n_bad++; $display("FAIL level_reset got q0=%b rises=%0d falls=%0d want 1 2 1", qv[0][0], r0, f0);
    end
  endtask

  task automatic test_clr_vs_set();
    s[3] = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (qv[0] !== 4'b1001 || anyv[0] !== 1'b1) begin
      n_bad++; $display("FAIL cvs_pre got q=%b any=%b want 1001 1", qv[0], anyv[0]);
    end
    clr = 4'b1001; tick(); clr = '0;
    n_cmp++; if (qv[0] !== 4'b0000 || anyv[0] !== 1'b0 || qf[0] !== 4'b1001 || qr[0] !== 4'b0000) begin
      n_bad++; $display("FAIL cvs_clr got q=%b any=%b fall=%b rise=%b want 0000 0 1001 0000", qv[0], anyv[0], qf[0], qr[0]);
    end
    tick();
    n_cmp++; if (qv[0] !== 4'b1000 || anyv[0] !== 1'b1 || qr[0] !== 4'b1000 || qf[0] !== 4'b0000) begin
      n_bad++; $display("FAIL cvs_reset got q=%b any=%b rise=%b fall=%b want 1000 1 1000 0000", qv[0], anyv[0], qr[0], qf[0]);
    end
    s[3] = 1'b0;
    tick(); tick();
    n_cmp++; if (qv[0] !== 4'b1000 || anyv[0] !== 1'b1 || qr[0] !== 4'b0000) begin
      n_bad++; $display("FAIL cvs_hold got q=%b any=%b rise=%b want 1000 1 0000", qv[0], anyv[0], qr[0]);
    end
  endtask

  task automatic test_reset_mid();
    s[1] = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (qv[d] !== 4'b0101 || qr[d] !== 4'b0000 || qf[d] !== 4'b0000 || anyv[d] !== 1'b1) begin
        n_bad++; $display("FAIL mid_reset dut%0d got q=%b rise=%b fall=%b any=%b want 0101 0000 0000 1",
                          d, qv[d], qr[d], qf[d], anyv[d]);
      end
    end
    tick(); tick(); tick();
    rst = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        n_cmp++; if (qv[d][1] !== (t >= 3) || qr[d][1] !== (t == 3)) begin
          n_bad++; $display("FAIL release t%0d dut%0d got q1=%b rise1=%b want %b %b",
                            t, d, qv[d][1], qr[d][1], (t >= 3), (t == 3));
        end
      end
    end
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (qv[d] !== 4'b0111) begin n_bad++; $display("FAIL release_q dut%0d got %b want 0111", d, qv[d]); end
    end
    s[1] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_simultaneous();
    test_edge_clr();
    test_clr_vs_set();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/srl_bank.md
Name: srl_bank

Overview:
- Parametrised, clocked successor to the single-bit set/reset latch: a bank of CHANNELS independent set/reset flags, each driven by asynchronous set/reset request lines.
- Each request line passes through a multi-flop synchronizer, with optional edge-qualification, a configurable resolution for simultaneous set/reset, and a per-channel synchronous clear.
- Registered transition pulses are provided for downstream handshake and control logic in the async/sync boundary layer.

Parameters:
- CHANNELS, 4, number of independent flag channels (1..32).
- SYNC_STAGES, 2, synchronizer flops per s/r input (2..4).
- PRIORITY, 0, s&r resolution: 0 = reset-dominant, 1 = set-dominant, 2 = toggle (JK).
- EDGE_MODE, 0, 0 = level-sensitive requests; 1 = only rising edges of the synced s/r count as events.
- INIT, {CHANNELS{1'b0}}, per-channel reset value of q.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset; asserting clears all state immediately; deassertion is synchronous to clk externally.
- s  input  CHANNELS  asynchronous set requests, one per channel.
- r  input  CHANNELS  asynchronous reset requests, one per channel.
- clr  input  CHANNELS  synchronous (clk-domain) clear, not synchronized.
- q  output  CHANNELS  flag state.
- q_rise  output  CHANNELS  one-cycle pulse on the cycle q[i] becomes 1.
- q_fall  output  CHANNELS  one-cycle pulse on the cycle q[i] becomes 0.
- any_set  output  1  registered OR of next-q; equals |q every cycle.

Behaviour:
Reset (rst=0, async):
- q=INIT; q_rise=0; q_fall=0; any_set=|INIT.
- All synchronizer flops and edge-history flops are cleared to 0.

Synchronizer:
- s_sync[i] and r_sync[i] are the outputs of the final stage of the SYNC_STAGES-flop chain.
- No logic is placed between stages.

Event generation:
- EDGE_MODE=0: set_ev = s_sync, rst_ev = r_sync.
- EDGE_MODE=1: set_ev = s_sync & ~s_prev, rst_ev = r_sync & ~r_prev, where s_prev/r_prev are registered copies of s_sync/r_sync. An input held high through reset release yields exactly one event, SYNC_STAGES cycles after release.

Next-state resolution, per channel, highest priority first:
1. clr[i]=1 -> q_next=0.
2. set_ev&rst_ev:
   - PRIORITY=0 -> 0
   - PRIORITY=1 -> 1
   - PRIORITY=2 -> ~q
3. set_ev only -> 1.
4. rst_ev only -> 0.
5. Neither -> hold.

Outputs:
- q_rise = q_next & ~q, registered; q_fall = ~q_next & q, registered. Both update on the same edge as q. A hold or redundant set/clear produces no pulse.
- any_set is registered from |q_next.

Latency:
- An input change set up before clk edge 0 is captured at edge 0 and appears at s_sync after edge SYNC_STAGES-1.
- q changes at edge SYNC_STAGES, i.e. SYNC_STAGES+1 edges counting the capture. The same applies in both modes.
- clr takes effect at the next edge (latency 1).

Continuous requests:
- Level mode with s held: q stays 1. clr that cycle forces 0, and q returns to 1 on the following edge; q_fall and q_rise each pulse once.
- Edge mode with s held: no further events after the first.
- PRIORITY=2 level mode with s&r held: q toggles every cycle. This is intended and must not be flagged as an error.

Other rules:
- Channels are fully independent; no cross-channel interaction except any_set.
- Reset asserted mid-operation aborts in-flight synchronizer contents; there is no pending event after release except the held-input edge case above.
- Request pulses narrower than one clk period may be missed. Minimum guaranteed-capture pulse width is 2 clk periods.

Test Plan:
1. Reset values: CHANNELS=4, INIT=4'b0101, rst pulse -> q=0101, q_rise=q_fall=0, any_set=1; all held stable until first event.
2. Latency: SYNC_STAGES=2, s[2] 0->1 before edge 0 -> q[2]=1 and q_rise[2]=1 after edge 2; q_rise[2]=0 after edge 3; r[2] 3-cycle pulse -> q[2]=0 with one q_fall pulse.
3. Simultaneous s&r on ch1 held 4 cycles:
   - PRIORITY=0 -> q[1]=0.
   - PRIORITY=1 -> q[1]=1.
   - PRIORITY=2 (level) -> q[1] toggles 1,0,1,0 with alternating rise/fall pulses.
4. EDGE_MODE=1: s[0] held high 10 cycles, clr[0] asserted at cycle 6 -> q[0] set once, cleared at cycle 7, stays 0 (no re-set); exactly one q_rise and one q_fall.
5. clr vs set, level mode: s[3]=1 held and clr[3]=1 for one cycle -> q[3]=0 for one cycle then 1; any_set tracks |q every cycle.
6. Reset mid-operation: s[1] rises, rst asserted one cycle later for 3 cycles -> q=INIT immediately. EDGE_MODE=1 with s[1] still high -> q[1]=1 exactly SYNC_STAGES+1 edges after release; EDGE_MODE=0 -> same timing.
